// File: rtl/ofs_fim_pcie_ss_crdt_gate_pkg.sv
// Shared PCIe SS credit definitions: type/class encodings, update beat layout
// and the need/mapping helpers used by the TX credit gate.
package ofs_fim_pcie_ss_crdt_gate_pkg;

  localparam int CRDT_CNT_W    = 16;
  localparam int CRDT_DCRDT_DW = 4;
  localparam int CRDT_NUM      = 6;

  typedef enum logic [2:0] {
    CRDT_PH   = 3'd0,
    CRDT_NPH  = 3'd1,
    CRDT_CPLH = 3'd2,
    CRDT_PD   = 3'd4,
    CRDT_NPD  = 3'd5,
    CRDT_CPLD = 3'd6
  } crdt_type_e;

  typedef enum logic [1:0] {
    CLS_P    = 2'd0,
    CLS_NP   = 2'd1,
    CLS_CPL  = 2'd2,
    CLS_RSVD = 2'd3
  } req_class_e;

  typedef struct packed {
    logic [2:0]            idx;
    logic [CRDT_CNT_W-1:0] cnt;
  } crdt_upd_t;

  function automatic crdt_type_e hdr_type(input req_class_e cls);
    case (cls)
      CLS_NP:  return CRDT_NPH;
      CLS_CPL: return CRDT_CPLH;
      default: return CRDT_PH;
    endcase
  endfunction

  function automatic crdt_type_e dat_type(input req_class_e cls);
    case (cls)
      CLS_NP:  return CRDT_NPD;
      CLS_CPL: return CRDT_CPLD;
      default: return CRDT_PD;
    endcase
  endfunction

  // Dense slot order [PH,NPH,CPLH,PD,NPD,CPLD] skips the reserved index 3.
  function automatic logic [2:0] type_slot(input logic [2:0] t);
    return t[2] ? t - 3'd1 : t;
  endfunction

  function automatic logic [8:0] data_crdts(input logic has_data, input logic [9:0] len,
                                            input int dw);
    logic [10:0] l;
    l = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    if (!has_data) return 9'd0;
    return 9'((int'(l) + dw - 1) / dw);
  endfunction

endpackage

// File: rtl/ofs_fim_pcie_ss_crdt_gate_cnt.sv
// One credit type: cumulative limit and consumed counters with the modular
// sufficiency compare and the limit-regression check.
module ofs_fim_pcie_ss_crdt_gate_cnt
  import ofs_fim_pcie_ss_crdt_gate_pkg::*;
#(
  parameter int CNT_W = CRDT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [CNT_W-1:0] upd_cnt,
  input  logic             cons_en,
  input  logic [CNT_W-1:0] cons_n,
  input  logic [CNT_W-1:0] need,
  output logic [CNT_W-1:0] avail,
  output logic             sufficient,
  output logic             regress
);

  localparam logic [CNT_W-1:0] HALF = {1'b1, {(CNT_W-1){1'b0}}};

  logic [CNT_W-1:0] limit_reg;
  logic [CNT_W-1:0] consumed_reg;
  logic             limit_vld_reg;
  logic [CNT_W-1:0] margin;
  logic [CNT_W-1:0] upd_delta;

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_reg     <= '0;
      consumed_reg  <= '0;
      limit_vld_reg <= 1'b0;
    end else begin
      if (upd_en) begin
        limit_reg     <= upd_cnt;
        limit_vld_reg <= 1'b1;
      end
      if (cons_en) consumed_reg <= consumed_reg + cons_n;
    end
  end

  // Only modular differences are compared, so both counters may wrap freely.
  assign avail      = limit_reg - consumed_reg;
  assign margin     = avail - need;
  assign sufficient = limit_vld_reg && (margin <= HALF);
  assign upd_delta  = upd_cnt - limit_reg;
  assign regress    = upd_en && limit_vld_reg && (upd_delta > HALF);

endmodule

// File: rtl/ofs_fim_pcie_ss_crdt_gate.sv
// TX credit gate: tracks per-type PCIe credit limits from the SS update stream
// and admits one packet per cycle when its header and data credits are present.
module ofs_fim_pcie_ss_crdt_gate
  import ofs_fim_pcie_ss_crdt_gate_pkg::*;
#(
  parameter int CNT_W    = CRDT_CNT_W,
  parameter int DCRDT_DW = CRDT_DCRDT_DW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           crdt_tvalid,
  input  logic [18:0]                    crdt_tdata,
  input  logic                           req_valid,
  input  logic [1:0]                     req_class,
  input  logic                           req_has_data,
  input  logic [9:0]                     req_length,
  output logic                           req_ready,
  output logic [CRDT_NUM-1:0][CNT_W-1:0] crdt_avail,
  output logic                           crdt_err
);

  crdt_upd_t            upd;
  req_class_e           cls;
  logic                 upd_idx_ok;
  logic [2:0]           hslot;
  logic [2:0]           dslot;
  logic [8:0]           dneed;
  logic                 accept;
  logic [CRDT_NUM-1:0]  upd_en;
  logic [CRDT_NUM-1:0]  cons_en;
  logic [CRDT_NUM-1:0]  suff;
  logic [CRDT_NUM-1:0]  regress;
  logic                 crdt_err_reg;
  logic                 crdt_err_next;

  assign upd        = crdt_upd_t'(crdt_tdata);
  assign upd_idx_ok = (upd.idx[1:0] != 2'b11);
  assign cls        = req_class_e'(req_class);
  assign hslot      = type_slot(hdr_type(cls));
  assign dslot      = type_slot(dat_type(cls));
  assign dneed      = data_crdts(req_has_data, req_length, DCRDT_DW);

  // Header and data availability come from registered state only: zero-cycle accept.
  assign req_ready = req_valid && (cls != CLS_RSVD) && suff[hslot] &&
                     ((dneed == 9'd0) || suff[dslot]);
  assign accept    = req_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CRDT_NUM; gi++) begin : g_cnt
      logic [CNT_W-1:0] need;
      if (gi < 3) begin : g_hdr
        assign need = CNT_W'(1);
      end else begin : g_dat
        assign need = CNT_W'(dneed);
      end
      assign upd_en[gi]  = crdt_tvalid && upd_idx_ok && (type_slot(upd.idx) == 3'(gi));
      assign cons_en[gi] = accept && ((hslot == 3'(gi)) || (dslot == 3'(gi)));

      ofs_fim_pcie_ss_crdt_gate_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .upd_en     (upd_en[gi]),
        .upd_cnt    (CNT_W'(upd.cnt)),
        .cons_en    (cons_en[gi]),
        .cons_n     (need),
        .need       (need),
        .avail      (crdt_avail[gi]),
        .sufficient (suff[gi]),
        .regress    (regress[gi])
      );
    end
  endgenerate

  assign crdt_err_next = crdt_err_reg
                       | (crdt_tvalid && !upd_idx_ok)
                       | (|regress)
                       | (req_valid && (cls == CLS_RSVD));

  always_ff @(posedge clk) begin
    if (rst) crdt_err_reg <= 1'b0;
    else     crdt_err_reg <= crdt_err_next;
  end

  assign crdt_err = crdt_err_reg;

endmodule

// File: doc/ofs_fim_pcie_ss_crdt_gate.md
Name: ofs_fim_pcie_ss_crdt_gate

Overview:
Consumer of the PCIe SS credit-update stream. Each beat carries {3-bit credit type index, 16-bit cumulative credit limit}.
- Tracks the cumulative limit and the cumulative consumed credits for each of the six PCIe credit types.
- Admits one packet-level request per cycle only when the header and data credits it needs are available.
- Sits between the FIM TX arbiter and the PCIe SS TX stream. The update stream has already been moved into clk.

Parameters:
- CNT_W, 16, width of the cumulative limit and consumed counters (modulo-2^CNT_W arithmetic).
- DCRDT_DW, 4, DWORDs covered by one data credit.

Ports:
- clk  in  1  block clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- crdt_tvalid  in  1  credit update valid; no backpressure.
- crdt_tdata  in  19  [18:16] type index (PH=0, NPH=1, CPLH=2, PD=4, NPD=5, CPLD=6); [15:0] cumulative limit.
- req_valid  in  1  candidate packet present; held stable until accepted.
- req_class  in  2  0=P, 1=NP, 2=CPL, 3=reserved.
- req_has_data  in  1  packet carries payload.
- req_length  in  10  payload length in DW; 0 encodes 1024.
- req_ready  out  1  packet admitted this cycle when req_valid && req_ready.
- crdt_avail  out  6x16  limit minus consumed per type, packed in index order [PH,NPH,CPLH,PD,NPD,CPLD]; debug only.
- crdt_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - limit[*]=0, limit_vld[*]=0, consumed[*]=0, crdt_err=0.
  - req_ready=0, because limit_vld is clear.
- Update path: on crdt_tvalid with a valid index, limit[idx] and limit_vld[idx] are registered and take effect on the next cycle.
  - Reserved index 3 or 7: the update is dropped and crdt_err is set.
  - Regression check: if limit_vld[idx] is already set and (new - old) mod 2^16 > 2^15, set crdt_err. The new value is still loaded.
- Need computation (combinational):
  - hneed = 1 for classes 0-2.
  - dneed = has_data ? ceil(L/DCRDT_DW) : 0, where L = (length==0 ? 1024 : length). dneed is 9 bits, max 256.
- Admission rule, PCIe gating rule: sufficient(t,n) = limit_vld[t] && ((limit[t] - consumed[t] - n) mod 2^16) <= 2^15.
  - req_ready = req_valid && class!=3 && sufficient(H of class, hneed) && (dneed==0 || sufficient(D of class, dneed)).
  - When dneed==0, limit_vld of the data type is not required.
  - req_ready is combinational from registered state plus request fields. Accept latency is 0 cycles.
- Consume path: on accept, consumed[H] += 1 and consumed[D] += dneed. Both wrap modulo 2^16 and are visible the next cycle, so back-to-back accepts see the prior accept.
- Simultaneous update and accept in one cycle: both apply. That cycle's admission uses the old limit, which is conservative.
- Class 3 with req_valid: never admitted; crdt_err is set on that cycle.
- Wrap-around: counters wrap freely; comparisons use only the modular difference.
- Mid-operation reset: every state returns to its reset value at the next edge and all credits become unavailable until fresh updates arrive. Upstream must drop any in-flight request.
- No state machine beyond the per-type limit_vld flags. Roughly 6x2 counters, 1 comparator pair and a mux.

Decomposition:
- Shared package (pcie_ss credit pkg):
  - crdt_type_e index enum, shared with the RX credit return block.
  - Class enum and the class-to-header/data index mapping function.
  - Function for data credits from DW length.
  - Update-beat struct {idx[2:0], cnt[15:0]}.
- One sub-module: ofs_fim_pcie_ss_crdt_cnt. It holds a single type's limit, limit_vld and consumed registers, plus the sufficient() compare and regression check. It is instantiated six times.

Test Plan:
- Post-reset request P, no data -> req_ready=0 indefinitely. Then update PH=2 -> ready one cycle later. Two accepts leave crdt_avail[PH]=0 and the third request stalls.
- Updates PH=10 and PD=8, then P request with data length=32 DW -> accept; crdt_avail[PD]=0. A following length=1 request stalls until PD=9 arrives.
- length=0 (1024 DW) CPL with data, CPLD limit=255 -> stall. After CPLD limit=256 -> accept; consumed[CPLD]=256.
- Preload consumed[NPH] near 0xFFFF via accepts with limit=0x0002 (wrapped) -> accepts continue across the 16-bit wrap with no false stall.
- Update with idx=3 -> crdt_err=1, limits unchanged. Separately, PH update 0x0100 then 0x00F0 -> crdt_err=1.
- Update for PH coincident with an accepting P request at avail=1 -> exactly one accept that cycle. The next cycle reflects the new limit minus 1.
